// File: rtl/wb_stage.sv
// Write-back stage: selects the write-back value, owns the 32x32 register file,
// executes syscall (LED display / halt) and keeps cycle/retired counters.
// The write-back bus is exposed combinationally for ID/EX forwarding.
module wb_stage #(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic             in_CLK,
  input  logic             in_CLR,
  input  logic             in_EN,
  input  logic             in_valid,
  input  logic [31:0]      in_R,
  input  logic [31:0]      in_Memdata,
  input  logic [31:0]      in_pcout,
  input  logic [4:0]       in_wr_num,
  input  logic             in_RegWrite,
  input  logic             in_MemToReg,
  input  logic             in_JAL,
  input  logic             in_syscall,
  input  logic [4:0]       in_ra_num,
  input  logic [4:0]       in_rb_num,
  output logic [31:0]      out_ra,
  output logic [31:0]      out_rb,
  output logic [31:0]      out_wb_data,
  output logic [4:0]       out_wb_num,
  output logic             out_wb_we,
  output logic [31:0]      out_led,
  output logic             out_halt,
  output logic [CNT_W-1:0] out_cycles,
  output logic [CNT_W-1:0] out_retired
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        running;
  logic        retire;
  logic        sys_fire;
  logic        halt_req;
  logic [31:0] regs [0:31];

  // State register: reset always returns the stage to RUN
  always_ff @(posedge in_CLK) begin
    if (in_CLR) state <= ST_RUN;
    else        state <= state_next;
  end

  // Next state: a retiring syscall with the halt code in $v0 stops the processor
  always_comb begin
    state_next = state;
    if (state == ST_RUN && halt_req) state_next = ST_HALT;
  end

  // State-derived outputs and the running qualifier used by every update
  always_comb begin
    running  = (state == ST_RUN);
    out_halt = (state == ST_HALT);
  end

  // Write-back value select: link address beats load data beats ALU result
  always_comb begin
    if (in_JAL)           out_wb_data = in_pcout;
    else if (in_MemToReg) out_wb_data = in_Memdata;
    else                  out_wb_data = in_R;
  end

  // Effective write enable and retire/syscall qualifiers
  always_comb begin
    out_wb_num = in_wr_num;
    retire     = in_EN & in_valid & running;
    out_wb_we  = retire & in_RegWrite & (in_wr_num != 5'd0);
    sys_fire   = retire & in_syscall;
    halt_req   = sys_fire & (regs[2] == HALT_CODE);
  end

  // Register file: r0 is never written, so it stays at its reset value of zero
  always_ff @(posedge in_CLK) begin
    if (in_CLR) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (out_wb_we) begin
      regs[in_wr_num] <= out_wb_data;
    end
  end

  // Read ports with write-through bypass so ID sees this cycle's write-back
  always_comb begin
    out_ra = regs[in_ra_num];
    out_rb = regs[in_rb_num];
    if (out_wb_we && in_ra_num == in_wr_num) out_ra = out_wb_data;
    if (out_wb_we && in_rb_num == in_wr_num) out_rb = out_wb_data;
    if (in_ra_num == 5'd0) out_ra = 32'd0;
    if (in_rb_num == 5'd0) out_rb = 32'd0;
  end

  // LED display: a non-halting syscall shows $a0 as it was before this edge
  always_ff @(posedge in_CLK) begin
    if (in_CLR)                    out_led <= 32'd0;
    else if (sys_fire && !halt_req) out_led <= regs[4];
  end

  // Cycle counter runs through stalls, freezes once halted, wraps naturally
  always_ff @(posedge in_CLK) begin
    if (in_CLR)       out_cycles <= '0;
    else if (running) out_cycles <= out_cycles + CNT_W'(1);
  end

  // Retired counter includes the halting syscall itself
  always_ff @(posedge in_CLK) begin
    if (in_CLR)      out_retired <= '0;
    else if (retire) out_retired <= out_retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed literal checks plus randomized
// traffic compared every cycle against a behavioural register-file model.
module tb_wb_stage;

  typedef struct packed {
    logic        clr;
    logic        en;
    logic        valid;
    logic [31:0] r;
    logic [31:0] mem;
    logic [31:0] pc;
    logic [4:0]  wr;
    logic        regwrite;
    logic        memtoreg;
    logic        jal;
    logic        syscall;
    logic [4:0]  ra;
    logic [4:0]  rb;
  } stim_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        en = 1'b0, valid = 1'b0;
  logic [31:0] r = '0, mem = '0, pc = '0;
  logic [4:0]  wr = '0, ra = '0, rb = '0;
  logic        regwrite = 1'b0, memtoreg = 1'b0, jal = 1'b0, syscall = 1'b0;

  logic [31:0] out_ra, out_rb, out_wb_data, out_led, out_cycles, out_retired;
  logic [4:0]  out_wb_num;
  logic        out_wb_we, out_halt;

  logic [31:0] s_ra, s_rb, s_wb_data, s_led;
  logic [3:0]  s_cycles, s_retired;
  logic [4:0]  s_wb_num;
  logic        s_wb_we, s_halt;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  logic [31:0] m_reg [32];
  logic [31:0] m_led;
  bit          m_halted;
  int unsigned m_cycles, m_retired;
  bit          model_ready = 0;

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(32), .HALT_CODE(32'd10)) dut (
    .in_CLK(clk), .in_CLR(clr), .in_EN(en), .in_valid(valid), .in_R(r),
    .in_Memdata(mem), .in_pcout(pc), .in_wr_num(wr), .in_RegWrite(regwrite),
    .in_MemToReg(memtoreg), .in_JAL(jal), .in_syscall(syscall),
    .in_ra_num(ra), .in_rb_num(rb), .out_ra(out_ra), .out_rb(out_rb),
    .out_wb_data(out_wb_data), .out_wb_num(out_wb_num), .out_wb_we(out_wb_we),
    .out_led(out_led), .out_halt(out_halt), .out_cycles(out_cycles),
    .out_retired(out_retired)
  );

  wb_stage #(.CNT_W(4), .HALT_CODE(32'd10)) dut4 (
    .in_CLK(clk), .in_CLR(clr), .in_EN(en), .in_valid(valid), .in_R(r),
    .in_Memdata(mem), .in_pcout(pc), .in_wr_num(wr), .in_RegWrite(regwrite),
    .in_MemToReg(memtoreg), .in_JAL(jal), .in_syscall(syscall),
    .in_ra_num(ra), .in_rb_num(rb), .out_ra(s_ra), .out_rb(s_rb),
    .out_wb_data(s_wb_data), .out_wb_num(s_wb_num), .out_wb_we(s_wb_we),
    .out_led(s_led), .out_halt(s_halt), .out_cycles(s_cycles),
    .out_retired(s_retired)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    clr = s.clr; en = s.en; valid = s.valid; r = s.r; mem = s.mem; pc = s.pc;
    wr = s.wr; regwrite = s.regwrite; memtoreg = s.memtoreg; jal = s.jal;
    syscall = s.syscall; ra = s.ra; rb = s.rb;
  endtask

  function automatic stim_t idle_stim(input logic [4:0] rda, input logic [4:0] rdb);
    stim_t s = '0;
    s.en = 1'b1;
    s.ra = rda;
    s.rb = rdb;
    return s;
  endfunction

  function automatic stim_t write_stim(input logic [4:0] dst, input logic [31:0] val);
    stim_t s = idle_stim(5'd0, 5'd0);
    s.valid = 1'b1;
    s.regwrite = 1'b1;
    s.wr = dst;
    s.r = val;
    return s;
  endfunction

  function automatic logic [31:0] sel_value();
    if (jal)      return pc;
    if (memtoreg) return mem;
    return r;
  endfunction

  // Model update: architectural effect of the instruction sitting in WB at this edge
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      m_led = 0; m_halted = 0; m_cycles = 0; m_retired = 0;
      model_ready = 1;
    end else if (model_ready && !m_halted) begin
      m_cycles++;
      if (en && valid) begin
        m_retired++;
        if (syscall) begin
          if (m_reg[2] == 32'd10) m_halted = 1;
          else m_led = m_reg[4];
        end
        if (regwrite && wr != 0) m_reg[wr] = sel_value();
      end
    end
  end

  // Compare process: every negedge, all outputs against the model
  always @(negedge clk) begin
    if (model_ready) begin
      logic        we;
      logic [31:0] d, ea, eb;
      we = en && valid && regwrite && (wr != 0) && !m_halted;
      d  = sel_value();
      ea = (ra == 0) ? 32'd0 : (we && ra == wr) ? d : m_reg[ra];
      eb = (rb == 0) ? 32'd0 : (we && rb == wr) ? d : m_reg[rb];
      checkOutput("wb_data", out_wb_data, d);
      checkOutput("wb_num", {27'd0, out_wb_num}, {27'd0, wr});
      checkOutput("wb_we", {31'd0, out_wb_we}, {31'd0, we});
      checkOutput("ra", out_ra, ea);
      checkOutput("rb", out_rb, eb);
      checkOutput("led", out_led, m_led);
      checkOutput("halt", {31'd0, out_halt}, {31'd0, m_halted});
      checkOutput("cycles", out_cycles, m_cycles);
      checkOutput("retired", out_retired, m_retired);
      checkOutput("cycles4", {28'd0, s_cycles}, m_cycles & 32'hF);
      checkOutput("retired4", {28'd0, s_retired}, m_retired & 32'hF);
      checkOutput("halt4", {31'd0, s_halt}, {31'd0, m_halted});
    end
  end

  initial begin
    stim_t s;
    // reset
    s = idle_stim(5'd0, 5'd0); s.clr = 1'b1;
    applyStimulus(s);
    applyStimulus(idle_stim(5'd0, 5'd0));
    #2;
    checkOutput("lit_reset_cycles", out_cycles, 32'd0);
    checkOutput("lit_reset_led", out_led, 32'd0);

    // write r5 then read it back
    s = write_stim(5'd5, 32'h1234); s.ra = 5'd5;
    applyStimulus(s); #2;
    checkOutput("lit_bypass_ra", out_ra, 32'h1234);
    applyStimulus(idle_stim(5'd5, 5'd0)); #2;
    checkOutput("lit_read_r5", out_ra, 32'h1234);
    checkOutput("lit_retired1", out_retired, 32'd1);
    checkOutput("lit_cycles2", out_cycles, 32'd2);

    // same-cycle bypass on port B, and write to r0
    s = write_stim(5'd7, 32'hCAFE); s.rb = 5'd7;
    applyStimulus(s); #2;
    checkOutput("lit_bypass_rb", out_rb, 32'hCAFE);
    s = write_stim(5'd0, 32'h55);
    applyStimulus(s); #2;
    checkOutput("lit_r0_we", {31'd0, out_wb_we}, 32'd0);
    checkOutput("lit_r0_read", out_ra, 32'd0);

    // write-back select priority
    s = idle_stim(5'd0, 5'd0); s.jal = 1; s.memtoreg = 1;
    s.pc = 32'h400; s.mem = 32'h777; s.r = 32'h1;
    applyStimulus(s); #2;
    checkOutput("lit_sel_jal", out_wb_data, 32'h400);
    s.jal = 0;
    applyStimulus(s); #2;
    checkOutput("lit_sel_mem", out_wb_data, 32'h777);

    // display syscall
    applyStimulus(write_stim(5'd2, 32'd1));
    applyStimulus(write_stim(5'd4, 32'hDEAD));
    s = idle_stim(5'd0, 5'd0); s.valid = 1; s.syscall = 1;
    applyStimulus(s);
    applyStimulus(idle_stim(5'd0, 5'd0)); #2;
    checkOutput("lit_led", out_led, 32'hDEAD);
    checkOutput("lit_no_halt", {31'd0, out_halt}, 32'd0);

    // halting syscall, writes ignored afterwards, reset recovers
    applyStimulus(write_stim(5'd2, 32'd10));
    s = idle_stim(5'd0, 5'd0); s.valid = 1; s.syscall = 1;
    applyStimulus(s);
    s = write_stim(5'd9, 32'h99); s.ra = 5'd9;
    applyStimulus(s); #2;
    checkOutput("lit_halted", {31'd0, out_halt}, 32'd1);
    checkOutput("lit_halt_we", {31'd0, out_wb_we}, 32'd0);
    applyStimulus(idle_stim(5'd9, 5'd0)); #2;
    checkOutput("lit_halt_nowrite", out_ra, 32'd0);
    s = idle_stim(5'd0, 5'd0); s.clr = 1'b1;
    applyStimulus(s);
    applyStimulus(idle_stim(5'd2, 5'd4)); #2;
    checkOutput("lit_clr_halt", {31'd0, out_halt}, 32'd0);
    checkOutput("lit_clr_r2", out_ra, 32'd0);
    checkOutput("lit_clr_led", out_led, 32'd0);
    checkOutput("lit_clr_retired", out_retired, 32'd0);

    // stall: no write, no retire, cycles still advance
    s = write_stim(5'd5, 32'h111); s.en = 1'b0;
    applyStimulus(s); #2;
    checkOutput("lit_stall_we", {31'd0, out_wb_we}, 32'd0);
    applyStimulus(idle_stim(5'd5, 5'd0)); #2;
    checkOutput("lit_stall_read", out_ra, 32'd0);
    checkOutput("lit_stall_retired", out_retired, 32'd0);
    checkOutput("lit_stall_cycles", out_cycles, 32'd2);
    for (int i = 0; i < 14; i++) applyStimulus(idle_stim(5'd0, 5'd0));
    #2;
    checkOutput("lit_wrap4", {28'd0, s_cycles}, 32'd0);
    checkOutput("lit_cycles16", out_cycles, 32'd16);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      s = '0;
      s.clr      = ($urandom_range(0, 79) == 0);
      s.en       = ($urandom_range(0, 5) != 0);
      s.valid    = ($urandom_range(0, 4) != 0);
      s.regwrite = ($urandom_range(0, 2) != 0);
      s.memtoreg = $urandom_range(0, 1);
      s.jal      = ($urandom_range(0, 4) == 0);
      s.syscall  = ($urandom_range(0, 9) == 0);
      s.wr       = 5'($urandom_range(0, 7));
      s.r        = ($urandom_range(0, 3) == 0) ? 32'd10 : $urandom;
      s.mem      = ($urandom_range(0, 3) == 0) ? 32'd10 : $urandom;
      s.pc       = $urandom;
      s.ra       = ($urandom_range(0, 2) == 0) ? s.wr : 5'($urandom_range(0, 31));
      s.rb       = ($urandom_range(0, 2) == 0) ? s.wr : 5'($urandom_range(0, 31));
      applyStimulus(s);
    end
    @(posedge clk);
    #2;
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
